// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master with configurable word width, compile-time CPOL/CPHA,
// MSB/LSB-first ordering and one-hot active-low slave selects.
// sck is derived in the clk domain: each half-period lasts HALF = FCLK/(2*BAUDRATE)
// clk cycles (at least one).
// Optional feature macro: SPI_MASTER_GEN_BURST_EN -- a start in the done cycle chains
// the next word straight into SETUP, with no GAP and no select glitch.
module spi_master_gen #(
  parameter int unsigned FCLK      = 100000000,
  parameter int unsigned BAUDRATE  = 9600,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NSS       = 1,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned LSB_FIRST = 0,
  localparam int unsigned CSW      = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CSW-1:0]   cs_sel,
  input  logic [WIDTH-1:0] tx,
  output logic [WIDTH-1:0] rx,
  output logic             busy,
  output logic             done,
  output logic [NSS-1:0]   ss,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned HALF_RAW = FCLK / (2 * BAUDRATE);
  localparam int unsigned HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;
  localparam int unsigned DIVW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned EDGES    = 2 * WIDTH;
  localparam int unsigned EW       = $clog2(EDGES + 1);
  localparam bit          CPOL_B   = (CPOL != 0);
  localparam bit          CPHA_B   = (CPHA != 0);
  localparam bit          LSBF     = (LSB_FIRST != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [CSW-1:0]   cs_q, cs_d;
  logic [WIDTH-1:0] txsh_q, txsh_d;
  logic [WIDTH-1:0] rxsh_q, rxsh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [NSS-1:0]   ss_q, ss_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;

  logic tick_c;
  logic accept_c;
  logic toggle_c;
  logic lead_c;
  logic trail_c;
  logic last_c;
  logic sample_c;
  logic shift_c;
  logic drive_first_c;

  // First bit on the wire for a given word
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSBF ? w[0] : w[WIDTH-1];
  endfunction

  // Advance the transmit word by one bit position
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return LSBF ? (w >> 1) : (w << 1);
  endfunction

  // Insert a received bit so the final word has the same ordering as tx
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return LSBF ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
  endfunction

  // Edge classification of the current half-period end
  always_comb begin
    tick_c        = (div_q == DIVW'(HALF - 1));
    toggle_c      = (state_q == ST_XFER) && tick_c;
    lead_c        = toggle_c && !edge_q[0];
    trail_c       = toggle_c && edge_q[0];
    last_c        = (edge_q == EW'(EDGES - 1));
    sample_c      = CPHA_B ? trail_c : lead_c;
    shift_c       = CPHA_B ? (lead_c && (edge_q != '0)) : (trail_c && !last_c);
    drive_first_c = CPHA_B && lead_c && (edge_q == '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: phase sequencing and divider/edge counters
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    edge_d   = edge_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        edge_d = '0;
        if (start) begin
          state_d  = ST_SETUP;
          accept_c = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick_c) begin
          state_d = ST_XFER;
          div_d   = '0;
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      ST_XFER: begin
        if (tick_c) begin
          div_d  = '0;
          edge_d = edge_q + EW'(1);
          if (last_c) begin
            state_d = ST_HOLD;
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          div_d  = '0;
          edge_d = '0;
`ifdef SPI_MASTER_GEN_BURST_EN
          if (start) begin
            state_d  = ST_SETUP;
            accept_c = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
`else
          state_d = ST_GAP;
`endif
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        edge_d  = '0;
      end
    endcase
  end

  // Output/datapath next values; every output is registered from these
  always_comb begin
    cs_d   = cs_q;
    txsh_d = txsh_q;
    rxsh_d = rxsh_q;
    rx_d   = rx_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    ss_d   = '1;

    if (accept_c) begin
      cs_d   = cs_sel;
      txsh_d = tx;
      rxsh_d = '0;
      mosi_d = CPHA_B ? 1'b0 : first_bit(tx);
    end

    if (toggle_c) begin
      sck_d = ~sck_q;
    end

    if (sample_c) begin
      rxsh_d = shift_in(rxsh_q, miso);
    end

    if (shift_c) begin
      txsh_d = shift_out(txsh_q);
      mosi_d = first_bit(shift_out(txsh_q));
    end

    if (drive_first_c) begin
      mosi_d = first_bit(txsh_q);
    end

    // The last HOLD cycle is the done cycle; rx is published with it
    if ((state_d == ST_HOLD) && (div_d == DIVW'(HALF - 1))) begin
      done_d = 1'b1;
      rx_d   = rxsh_d;
    end

    // Out-of-range selects match no line, so all stay high
    if ((state_d == ST_SETUP) || (state_d == ST_XFER) || (state_d == ST_HOLD)) begin
      for (int i = 0; i < int'(NSS); i++) begin
        if (cs_d == CSW'(i)) begin
          ss_d[i] = 1'b0;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      edge_q <= '0;
      cs_q   <= '0;
      txsh_q <= '0;
      rxsh_q <= '0;
      rx_q   <= '0;
      ss_q   <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sck_q  <= CPOL_B;
      mosi_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      cs_q   <= cs_d;
      txsh_q <= txsh_d;
      rxsh_q <= rxsh_d;
      rx_q   <= rx_d;
      ss_q   <= ss_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
    end
  end

  assign rx   = rx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ss   = ss_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: loopback instances (8-bit/NSS=3 and 16-bit LSB-first/NSS=4)
// plus four mode instances (HALF forced to 1) talking to a mode-matched slave model.
module tb_spi_master_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Main instance: HALF=5, 8-bit, 3 selects, mode 0, loopback
  logic       m_start = 1'b0;
  logic [1:0] m_cs    = '0;
  logic [7:0] m_tx    = '0;
  logic [7:0] m_rx;
  logic       m_busy, m_done, m_sck, m_mosi;
  logic [2:0] m_ss;

  spi_master_gen #(.FCLK(100000000), .BAUDRATE(10000000), .WIDTH(8), .NSS(3)) u_main (
    .clk(clk), .rst(rst), .start(m_start), .cs_sel(m_cs), .tx(m_tx), .rx(m_rx),
    .busy(m_busy), .done(m_done), .ss(m_ss), .sck(m_sck), .mosi(m_mosi), .miso(m_mosi));

  // Wide instance: HALF=5, 16-bit, LSB first, 4 selects, loopback
  logic        w_start = 1'b0;
  logic [1:0]  w_cs    = '0;
  logic [15:0] w_tx    = '0;
  logic [15:0] w_rx;
  logic        w_busy, w_done, w_sck, w_mosi;
  logic [3:0]  w_ss;

  spi_master_gen #(.FCLK(100000000), .BAUDRATE(10000000), .WIDTH(16), .NSS(4),
                   .LSB_FIRST(1)) u_wide (
    .clk(clk), .rst(rst), .start(w_start), .cs_sel(w_cs), .tx(w_tx), .rx(w_rx),
    .busy(w_busy), .done(w_done), .ss(w_ss), .sck(w_sck), .mosi(w_mosi), .miso(w_mosi));

  // Mode sweep instances, index = CPOL*2 + CPHA
  logic       md_start = 1'b0;
  logic [7:0] md_tx    = '0;
  logic       md_cs    = 1'b0;
  logic [7:0] md_rx   [4];
  logic       md_busy [4];
  logic       md_done [4];
  logic       md_ss   [4];
  logic       md_sck  [4];
  logic       md_mosi [4];
  logic       md_miso [4];
  logic [7:0] slv_rx  [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam bit SP = ((g / 2) != 0);
    localparam bit CH = ((g % 2) != 0);
    logic [7:0] s_rx;
    logic [7:0] s_tx;
    int         s_idx = 0;
    logic       s_first;
    logic       s_prev;

    spi_master_gen #(.FCLK(100000000), .BAUDRATE(60000000), .WIDTH(8), .NSS(1),
                     .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .rst(rst), .start(md_start), .cs_sel(md_cs), .tx(md_tx), .rx(md_rx[g]),
      .busy(md_busy[g]), .done(md_done[g]), .ss(md_ss[g]), .sck(md_sck[g]),
      .mosi(md_mosi[g]), .miso(md_miso[g]));

    // Slave returning 0x3C MSB first: samples on its sample edge, shifts on the other
    always @(md_sck[g] or md_ss[g]) begin
      if (md_ss[g]) begin
        s_idx   = 0;
        s_first = 1'b1;
        s_prev  = SP;
        s_tx    = 8'h3C;
      end else if (md_sck[g] != s_prev) begin
        s_prev = md_sck[g];
        if ((md_sck[g] != SP) ^ CH) begin
          s_rx = {s_rx[6:0], md_mosi[g]};
        end else if (CH && s_first) begin
          s_first = 1'b0;
        end else begin
          s_idx = s_idx + 1;
        end
      end
    end

    assign md_miso[g] = (s_idx < 8) ? s_tx[3'(7 - s_idx)] : 1'b0;
    assign slv_rx[g]  = s_rx;
  end

  // Scoreboard: expected words queued at stimulus, observed rx queued at done
  logic [7:0]  exp_q [$];
  logic [7:0]  obs_q [$];
  logic [15:0] wexp_q [$];

  int ss_low_n, edge_n, done_n, fall_n, bad_ss_n, done_at, busy_low_at;
  bit timed_out;

  task automatic drive_main(input logic [7:0] t, input logic [1:0] c);
    @(negedge clk);
    m_start = 1'b1;
    m_tx    = t;
    m_cs    = c;
    @(negedge clk);
    m_start = 1'b0;
  endtask

  // Observe u_main from the first busy cycle until busy drops; optional extra starts
  task automatic watch_main(input logic [2:0] ss_exp, input bit poke_mid,
                            input bit burst_poke, input logic [7:0] burst_tx);
    logic prev_sck;
    logic prev_hi;
    ss_low_n = 0; edge_n = 0; done_n = 0; fall_n = 0; bad_ss_n = 0;
    done_at = -1; busy_low_at = -1; timed_out = 1'b1;
    prev_sck = m_sck;
    prev_hi  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      m_start = 1'b0;
      if (m_ss != 3'b111) begin
        ss_low_n++;
        if (m_ss != ss_exp) bad_ss_n++;
        if (prev_hi) fall_n++;
      end
      prev_hi = (m_ss == 3'b111);
      if (m_sck != prev_sck) edge_n++;
      prev_sck = m_sck;
      if (poke_mid && i == 20) begin
        m_start = 1'b1;
        m_tx    = 8'hFF;
        m_cs    = 2'd0;
      end
      if (m_done) begin
        done_n++;
        done_at = i;
        obs_q.push_back(m_rx);
        if (burst_poke && done_n == 1) begin
          m_start = 1'b1;
          m_tx    = burst_tx;
        end
      end
      if (!m_busy) begin
        busy_low_at = i;
        timed_out   = 1'b0;
        break;
      end
      @(negedge clk);
    end
    m_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (m_ss !== 3'b111) begin n_err++; $display("FAIL reset_ss got=%b want=111", m_ss); end
    n_checks++; if (m_sck !== 1'b0) begin n_err++; $display("FAIL reset_sck got=%b want=0", m_sck); end
    n_checks++; if (m_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got=%b want=0", m_mosi); end
    n_checks++; if (m_rx !== 8'h00) begin n_err++; $display("FAIL reset_rx got=%h want=00", m_rx); end
    n_checks++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", m_busy); end
    n_checks++; if (m_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", m_done); end
    n_checks++; if (w_ss !== 4'hF) begin n_err++; $display("FAIL reset_wide_ss got=%b want=1111", w_ss); end
    n_checks++; if (md_sck[3] !== 1'b1) begin n_err++; $display("FAIL reset_cpol1_sck got=%b want=1", md_sck[3]); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback_mode0;
    logic [7:0] e, o;
    exp_q.push_back(8'hA5);
    drive_main(8'hA5, 2'd1);
    watch_main(3'b101, 1'b0, 1'b0, 8'h00);
    n_checks++; if (timed_out) begin n_err++; $display("FAIL lb_timeout busy never dropped"); end
    n_checks++; if (ss_low_n != 90) begin n_err++; $display("FAIL lb_ss_low got=%0d want=90", ss_low_n); end
    n_checks++; if (bad_ss_n != 0) begin n_err++; $display("FAIL lb_ss_onehot bad_cycles=%0d want=0", bad_ss_n); end
    n_checks++; if (edge_n != 16) begin n_err++; $display("FAIL lb_sck_edges got=%0d want=16", edge_n); end
    n_checks++; if (done_n != 1) begin n_err++; $display("FAIL lb_done_pulses got=%0d want=1", done_n); end
    n_checks++; if (done_at != 89) begin n_err++; $display("FAIL lb_done_at got=%0d want=89", done_at); end
    n_checks++; if (busy_low_at - done_at != 6) begin n_err++; $display("FAIL lb_gap got=%0d want=6", busy_low_at - done_at); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL lb_rx missing want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL lb_rx got=%h want=%h", o, e); end
      end
    end
    n_checks++; if (m_rx !== 8'hA5) begin n_err++; $display("FAIL lb_rx_hold got=%h want=a5", m_rx); end
    obs_q.delete();
  endtask

  task automatic test_ignore_outofrange;
    logic [7:0] e, o;
    int busy_seen;
    exp_q.push_back(8'h5A);
    drive_main(8'h5A, 2'd3);
    watch_main(3'b111, 1'b1, 1'b0, 8'h00);
    n_checks++; if (timed_out) begin n_err++; $display("FAIL oor_timeout busy never dropped"); end
    n_checks++; if (ss_low_n != 0) begin n_err++; $display("FAIL oor_ss_low got=%0d want=0", ss_low_n); end
    n_checks++; if (edge_n != 16) begin n_err++; $display("FAIL oor_sck_edges got=%0d want=16", edge_n); end
    n_checks++; if (done_n != 1) begin n_err++; $display("FAIL oor_done_pulses got=%0d want=1", done_n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL oor_rx missing want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL oor_rx got=%h want=%h", o, e); end
      end
    end
    obs_q.delete();
    busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_busy) busy_seen++;
    end
    n_checks++; if (busy_seen != 0) begin n_err++; $display("FAIL ignored_start_queued busy_cycles=%0d want=0", busy_seen); end
  endtask

  task automatic test_reset_mid;
    drive_main(8'hFF, 2'd0);
    repeat (30) @(negedge clk);
    n_checks++; if (m_mosi !== 1'b1 || m_ss !== 3'b110) begin
      n_err++; $display("FAIL mid_pre mosi=%b ss=%b want mosi=1 ss=110", m_mosi, m_ss);
    end
    rst = 1'b1;
    #1;
    n_checks++; if (m_ss !== 3'b111) begin n_err++; $display("FAIL mid_rst_ss got=%b want=111", m_ss); end
    n_checks++; if (m_sck !== 1'b0) begin n_err++; $display("FAIL mid_rst_sck got=%b want=0", m_sck); end
    n_checks++; if (m_mosi !== 1'b0) begin n_err++; $display("FAIL mid_rst_mosi got=%b want=0", m_mosi); end
    n_checks++; if (m_rx !== 8'h00) begin n_err++; $display("FAIL mid_rst_rx got=%h want=00", m_rx); end
    n_checks++; if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_flags busy=%b done=%b want 0 0", m_busy, m_done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wide_lsb;
    int ss2_n, bad_n, dn;
    logic first_mosi;
    logic [15:0] got, e;
    bit ended;
    wexp_q.push_back(16'h8001);
    @(negedge clk);
    w_start = 1'b1; w_tx = 16'h8001; w_cs = 2'd2;
    @(negedge clk);
    w_start = 1'b0;
    first_mosi = w_mosi;
    ss2_n = 0; bad_n = 0; dn = 0; got = '0; ended = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (w_ss == 4'b1011) ss2_n++;
      else if (w_ss != 4'b1111) bad_n++;
      if (w_done) begin dn++; got = w_rx; end
      if (!w_busy) begin ended = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ended) begin n_err++; $display("FAIL wide_timeout busy never dropped"); end
    n_checks++; if (first_mosi !== 1'b1) begin n_err++; $display("FAIL wide_first_bit got=%b want=1", first_mosi); end
    n_checks++; if (ss2_n != 170) begin n_err++; $display("FAIL wide_ss2_low got=%0d want=170", ss2_n); end
    n_checks++; if (bad_n != 0) begin n_err++; $display("FAIL wide_other_ss bad_cycles=%0d want=0", bad_n); end
    n_checks++; if (dn != 1) begin n_err++; $display("FAIL wide_done_pulses got=%0d want=1", dn); end
    e = wexp_q.pop_front();
    n_checks++; if (got !== e) begin n_err++; $display("FAIL wide_rx got=%h want=%h", got, e); end
  endtask

  task automatic test_mode_sweep;
    int dn [4];
    logic [7:0] got [4];
    logic [7:0] e;
    bit ended;
    for (int m = 0; m < 4; m++) begin
      exp_q.push_back(8'h3C);
      dn[m] = 0;
      got[m] = '0;
    end
    @(negedge clk);
    md_start = 1'b1; md_tx = 8'hC3;
    @(negedge clk);
    md_start = 1'b0;
    ended = 1'b0;
    for (int i = 0; i < 200; i++) begin
      for (int m = 0; m < 4; m++) begin
        if (md_done[m]) begin dn[m]++; got[m] = md_rx[m]; end
      end
      if (!md_busy[0] && !md_busy[1] && !md_busy[2] && !md_busy[3]) begin ended = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ended) begin n_err++; $display("FAIL mode_timeout busy never dropped"); end
    for (int m = 0; m < 4; m++) begin
      e = exp_q.pop_front();
      n_checks++; if (dn[m] != 1) begin n_err++; $display("FAIL mode%0d_done got=%0d want=1", m, dn[m]); end
      n_checks++; if (got[m] !== e) begin n_err++; $display("FAIL mode%0d_master_rx got=%h want=%h", m, got[m], e); end
      n_checks++; if (slv_rx[m] !== 8'hC3) begin n_err++; $display("FAIL mode%0d_slave_rx got=%h want=c3", m, slv_rx[m]); end
      n_checks++; if (md_sck[m] !== 1'(m / 2)) begin n_err++; $display("FAIL mode%0d_sck_idle got=%b want=%0d", m, md_sck[m], m / 2); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e, o;
    int want_low, want_done, want_edges;
    exp_q.push_back(8'h11);
`ifdef SPI_MASTER_GEN_BURST_EN
    exp_q.push_back(8'h22);
    want_low = 180; want_done = 2; want_edges = 32;
`else
    want_low = 90; want_done = 1; want_edges = 16;
`endif
    drive_main(8'h11, 2'd2);
    watch_main(3'b011, 1'b0, 1'b1, 8'h22);
    n_checks++; if (timed_out) begin n_err++; $display("FAIL b2b_timeout busy never dropped"); end
    n_checks++; if (ss_low_n != want_low) begin n_err++; $display("FAIL b2b_ss_low got=%0d want=%0d", ss_low_n, want_low); end
    n_checks++; if (fall_n != 1) begin n_err++; $display("FAIL b2b_ss_falls got=%0d want=1", fall_n); end
    n_checks++; if (bad_ss_n != 0) begin n_err++; $display("FAIL b2b_ss_onehot bad_cycles=%0d want=0", bad_ss_n); end
    n_checks++; if (done_n != want_done) begin n_err++; $display("FAIL b2b_done_pulses got=%0d want=%0d", done_n, want_done); end
    n_checks++; if (edge_n != want_edges) begin n_err++; $display("FAIL b2b_sck_edges got=%0d want=%0d", edge_n, want_edges); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL b2b_rx missing want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL b2b_rx got=%h want=%h", o, e); end
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_err++; $display("FAIL b2b_extra_words got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_loopback_mode0();
    test_ignore_outofrange();
    test_reset_mid();
    test_wide_lsb();
    test_mode_sweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
